jk_cmd_scheduler: RTL and testbench

Shares one bank of WIDTH JK flip-flop cells between NREQ independent requesters. Each requester issues J/K commands (hold, clear, set, toggle) with a per-bit mask over a valid/ready handshake. A round-robin arbiter grants one command per cycle. The granted command is registered and applied to the bank on the following edge, and an acknowledge identifies the requester it served. The block sits between the control agents and the shared JK state register, whose value is exported on `q`.

---
 rtl/jk_sched_pkg.sv | 22 ++
 rtl/jk_cmd_scheduler_if.sv | 31 +++
 rtl/rr_arbiter.sv | 56 +++++
 rtl/jk_cmd_scheduler.sv | 94 +++++++++
 tb/tb_jk_cmd_scheduler.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/jk_sched_pkg.sv
// Shared definitions for the JK command scheduler.
//   jk_op_e  : J/K command encoding, {J,K} (hold, clear, set, toggle)
//   jk_next  : next value of one JK cell given its current value and a command
package jk_sched_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_CLEAR  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_op_e;

  function automatic logic jk_next(input logic q, input jk_op_e op);
    case (op)
      JK_HOLD:  return q;
      JK_CLEAR: return 1'b0;
      JK_SET:   return 1'b1;
      default:  return ~q;
    endcase
  endfunction

endpackage

// File: rtl/jk_cmd_scheduler_if.sv
// Requester-side command bus of the JK command scheduler.
//   req_valid[i]                        : requester i has a command
//   req_op[2i+1:2i]                     : requester i command, {J,K}
//   req_mask[WIDTH*i+WIDTH-1:WIDTH*i]   : requester i bit mask, 1 = bit affected
//   req_ready[i]                        : requester i is granted this cycle
// master = requesters, slave = scheduler.
interface jk_cmd_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);

  logic [NREQ-1:0]       req_valid;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_mask;
  logic [NREQ-1:0]       req_ready;

  modport master (
    output req_valid,
    output req_op,
    output req_mask,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_mask,
    output req_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
//   clk, rst_n : clock, synchronous active-low reset
//   req        : request vector
//   advance    : the current grant was taken; move the pointer past it
//   grant      : combinational one-hot grant (zero while in reset or idle)
//   grant_id   : index of the granted requester (0 when nothing is granted)
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           advance,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id
);

  logic [IDW-1:0] ptr;

  // Scan ptr, ptr+1, ... mod N; the first requester found wins.
  always_comb begin
    logic found;
    int   idx;
    // NOTE: every variable gets a default before any conditional write so
    // no path leaves it unassigned and no latch is inferred.
    found    = 1'b0;
    idx      = 0;
    grant    = '0;
    grant_id = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = IDW'(idx);
      end
    end
    // Nothing may be accepted while the block is held in reset.
    if (!rst_n) begin
      grant = '0;
    end
  end

  // The requester just served drops to lowest priority.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/jk_cmd_scheduler.sv
// Shares one bank of WIDTH JK cells between NREQ requesters.
// One command per cycle is granted round-robin, captured in a stage register,
// applied to the bank on the next edge and acknowledged together with the
// resulting q.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : requester command bus (slave side)
//   q          : JK bank state
//   ack_valid  : one-cycle pulse per applied command, coincides with new q
//   ack_id     : requester served by the current ack
module jk_cmd_scheduler
  import jk_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  jk_cmd_scheduler_if.slave bus,
  output logic [WIDTH-1:0] q,
  output logic             ack_valid,
  output logic [IDW-1:0]   ack_id
);

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_id;
  logic             accept;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_mask;

  logic             stg_valid;
  jk_op_e           stg_op;
  logic [WIDTH-1:0] stg_mask;
  logic [IDW-1:0]   stg_id;

  logic [WIDTH-1:0] q_next;

  rr_arbiter #(
    .N   (NREQ),
    .IDW (IDW)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (bus.req_valid),
    .advance  (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign bus.req_ready = grant;
  assign accept        = |(bus.req_valid & grant);

  // Command fields of the granted requester.
  assign sel_op   = bus.req_op[2*int'(grant_id) +: 2];
  assign sel_mask = bus.req_mask[WIDTH*int'(grant_id) +: WIDTH];

  // Masked bits follow the staged JK command, the rest keep their value.
  always_comb begin
    q_next = q;
    for (int b = 0; b < WIDTH; b++) begin
      if (stg_mask[b]) begin
        q_next[b] = jk_next(q[b], stg_op);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the stage payload is reset along with its valid bit; it is
      // only consumed when stg_valid is set, but clearing it keeps the bank
      // free of X values after reset at negligible cost.
      stg_valid <= 1'b0;
      stg_op    <= JK_HOLD;
      stg_mask  <= '0;
      stg_id    <= '0;
      q         <= '0;
      ack_valid <= 1'b0;
      ack_id    <= '0;
    end else begin
      stg_valid <= accept;
      if (accept) begin
        stg_op   <= jk_op_e'(sel_op);
        stg_mask <= sel_mask;
        stg_id   <= grant_id;
      end
      if (stg_valid) begin
        q <= q_next;
      end
      ack_valid <= stg_valid;
      ack_id    <= stg_id;
    end
  end

endmodule

// File: tb/tb_jk_cmd_scheduler.sv
// Self-checking bench for jk_cmd_scheduler (NREQ=4, WIDTH=8).
// A stimulus process drives commands and predicts grants and resulting bank
// values from a word-level model; a separate monitor checks every cycle's ack
// against the expectation queue.
module tb_jk_cmd_scheduler;
  import jk_sched_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] q;
  logic             ack_valid;
  logic [IDW-1:0]   ack_id;

  jk_cmd_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  jk_cmd_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .q         (q),
    .ack_valid (ack_valid),
    .ack_id    (ack_id)
  );

  typedef struct {
    int         id;
    logic [7:0] q;
    int         due;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [7:0] q_model  = 8'h00;
  int         rr_next  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Word-level effect of one command on the bank.
  function automatic logic [7:0] model_apply(input logic [7:0] qv, input logic [1:0] op,
                                             input logic [7:0] m);
    case (op)
      2'b01:   return qv & ~m;
      2'b10:   return qv | m;
      2'b11:   return qv ^ m;
      default: return qv;
    endcase
  endfunction

  // Id of the first valid requester at or after start (wrapping), -1 if none.
  function automatic int model_pick(input logic [3:0] v, input int start);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  // One clock cycle of stimulus; returns at the following negedge.
  task automatic step(input logic rst, input logic [3:0] v, input logic [7:0] ops,
                      input logic [31:0] masks);
    int         id;
    logic [3:0] exp_ready;
    @(posedge clk);
    #1;
    rst_n         = rst;
    bus.req_valid = v;
    bus.req_op    = ops;
    bus.req_mask  = masks;
    if (!rst) begin
      // A reset at the next edge discards anything not yet applied.
      while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
      q_model = 8'h00;
      rr_next = 0;
    end
    @(negedge clk);
    id        = rst_n ? model_pick(v, rr_next) : -1;
    exp_ready = (id >= 0) ? 4'(1 << id) : 4'b0000;
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    if (id >= 0) begin
      q_model = model_apply(q_model, ops[2*id +: 2], masks[8*id +: 8]);
      sb.push_back('{id, q_model, cyc + 2});
      rr_next = (id + 1) % NREQ;
    end
  endtask

  task automatic send(input int id, input logic [1:0] op, input logic [7:0] m);
    step(1'b1, 4'(1 << id), 8'(op) << (2 * id), 32'(m) << (8 * id));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 4'b0000, 8'h00, 32'h0);
  endtask

  // Monitor: an ack is required exactly on the cycle its command is due.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("ack_valid", 32'(ack_valid), 32'd1);
      check("ack_id", 32'(ack_id), 32'(e.id));
      check("ack_q", 32'(q), 32'(e.q));
    end else begin
      check("ack_idle", 32'(ack_valid), 32'd0);
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_mask  = '0;

    // Reset held with all requesters valid, then release.
    step(1'b0, 4'hF, 8'h00, 32'h0);
    step(1'b0, 4'hF, 8'h00, 32'h0);
    check("q_in_reset", 32'(q), 32'h0);
    step(1'b1, 4'hF, 8'h00, 32'h0);
    idle(2);

    // Set, then toggle and clear from different requesters.
    send(1, JK_SET, 8'h0F);
    idle(2);
    send(2, JK_TOGGLE, 8'hFF);
    idle(1);
    send(3, JK_CLEAR, 8'h30);
    idle(2);
    check("q_after_clear", 32'(q), 32'hC0);

    // Fairness: everyone valid with hold/mask=0.
    for (int i = 0; i < 6; i++) step(1'b1, 4'hF, 8'h00, 32'h0);
    idle(2);
    check("q_after_holds", 32'(q), 32'hC0);

    // Back-to-back dependence.
    send(0, JK_SET, 8'hFF);
    send(1, JK_CLEAR, 8'h0F);
    idle(2);

    // Reset with a command in flight.
    send(0, JK_SET, 8'hAA);
    step(1'b0, 4'h0, 8'h00, 32'h0);
    step(1'b1, 4'h0, 8'h00, 32'h0);
    check("q_after_midreset", 32'(q), 32'h0);
    step(1'b1, 4'hF, 8'h00, 32'h0);
    idle(2);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(59) == 0) begin
        step(1'b0, 4'($urandom), 8'($urandom), $urandom);
      end else begin
        step(1'b1, 4'($urandom), 8'($urandom), $urandom);
      end
    end
    idle(4);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
